// File: rtl/pmod_pkg.sv
// rtl/pmod_pkg.sv - shared Pmod serial frame format and receiver state encoding
//
// Purpose: frame-format defaults shared by the Pmod ADC receiver and the Pmod DAC
// transmitter so both ends agree on the frame layout, plus the receiver state type.
// Ports: none (package).

package pmod_pkg;

  localparam int PMOD_WIDTH      = 12;  // sample bits kept per frame
  localparam int PMOD_FRAME_BITS = 16;  // sclk cycles per frame
  localparam int PMOD_LEAD_ZEROS = 4;   // leading bits discarded

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEAD,
    ST_SHIFT,
    ST_TAIL
  } pmod_state_t;

endpackage

// File: rtl/pmod_sclk_gen.sv
// rtl/pmod_sclk_gen.sv - serial clock half-period generator
//
// Purpose: produces the sclk level for the shift phase of a frame. Each level is
// held for DIV clock cycles. Outside a shift phase sclk idles high.
// Ports:
//   clock  - system clock
//   resetn - synchronous active-high reset
//   start  - forces sclk low and restarts the half-period count
//   run    - lets sclk toggle every DIV cycles; when low sclk returns high
//   sclk   - registered serial clock level
//   rise   - high in the cycle whose closing edge raises sclk
//   fall   - high in the cycle whose closing edge would lower sclk

module pmod_sclk_gen #(
  parameter int DIV = 2
) (
  input  logic clock,
  input  logic resetn,
  input  logic start,
  input  logic run,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] half_cnt;
  logic          half_end;

  assign half_end = (half_cnt == CW'(DIV - 1));
  // Strobes are decoded from the registered level so the caller can act on the
  // very edge at which sclk changes. When idle the count sits at 0, and DIV >= 2
  // keeps both strobes quiet.
  assign rise = ~sclk & half_end;
  assign fall = sclk & half_end;

  always_ff @(posedge clock) begin
    if (resetn) begin
      sclk     <= 1'b1;
      half_cnt <= '0;
    end else if (start) begin
      sclk     <= 1'b0;
      half_cnt <= '0;
    end else if (run) begin
      if (half_end) begin
        half_cnt <= '0;
        sclk     <= ~sclk;
      end else begin
        half_cnt <= half_cnt + CW'(1);
      end
    end else begin
      sclk     <= 1'b1;
      half_cnt <= '0;
    end
  end

endmodule

// File: rtl/pmod_adc_rx.sv
// rtl/pmod_adc_rx.sv - 12-bit Pmod ADC serial frame receiver
//
// Purpose: drives cs/sclk for one frame per SAMPLE_PERIOD, shifts sdata in MSB
// first, drops the leading bits and presents the sample with a one-cycle strobe.
// Ports:
//   clock   - system clock
//   resetn  - synchronous active-high reset
//   en      - enables conversions; a frame in progress always completes
//   sdata   - ADC serial data
//   cs      - chip select, active low
//   sclk    - serial clock, idles high
//   dataout - last sample, held between strobes
//   valid   - one-cycle pulse when dataout updates, coincident with cs rising
//   busy    - registered copy of ~cs

module pmod_adc_rx
  import pmod_pkg::*;
#(
  parameter int WIDTH         = PMOD_WIDTH,
  parameter int FRAME_BITS    = PMOD_FRAME_BITS,
  parameter int LEAD_ZEROS    = PMOD_LEAD_ZEROS,
  parameter int DIV           = 2,
  parameter int SAMPLE_PERIOD = 256,
  parameter bit SIGNED_OUT    = 1'b1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             en,
  input  logic             sdata,
  output logic             cs,
  output logic             sclk,
  output logic [WIDTH-1:0] dataout,
  output logic             valid,
  output logic             busy
);

  if (LEAD_ZEROS + WIDTH > FRAME_BITS) begin : g_bad_frame
    $error("pmod_adc_rx: LEAD_ZEROS + WIDTH exceeds FRAME_BITS");
  end
  if (DIV < 2) begin : g_bad_div
    $error("pmod_adc_rx: DIV must be at least 2");
  end
  if (SAMPLE_PERIOD < (2 * FRAME_BITS + 4) * DIV) begin : g_bad_period
    $error("pmod_adc_rx: SAMPLE_PERIOD too short for one frame plus cs gap");
  end

  localparam int PW   = $clog2(SAMPLE_PERIOD);
  localparam int BW   = $clog2(FRAME_BITS + 1);
  localparam int WW   = $clog2(DIV);
  // Only the bits after the leading ones are worth storing.
  localparam int KEEP = FRAME_BITS - LEAD_ZEROS;
  // Offset binary becomes two's complement by flipping the MSB.
  localparam logic [WIDTH-1:0] MSB_MASK = SIGNED_OUT ? (WIDTH'(1) << (WIDTH - 1)) : '0;

  pmod_state_t      state;
  logic [PW-1:0]    period_cnt;
  logic [WW-1:0]    wait_cnt;
  logic [BW-1:0]    bit_cnt;
  logic [KEEP-1:0]  shreg;
  logic             sdata_q;
  logic             sclk_rise;
  logic             sclk_fall;
  logic             gen_start;
  logic             gen_run;
  logic             wait_done;
  logic             shift_done;
  logic [WIDTH-1:0] frame_sample;

  assign wait_done    = (wait_cnt == WW'(DIV - 1));
  assign gen_start    = (state == ST_LEAD) && wait_done;
  // The shift phase ends where the last high half-period would fall; holding
  // sclk high there merges it into the TAIL high time.
  assign shift_done   = (state == ST_SHIFT) && sclk_fall && (bit_cnt == BW'(FRAME_BITS));
  assign gen_run      = (state == ST_SHIFT) && !shift_done;
  assign frame_sample = shreg[KEEP-1 -: WIDTH];

  pmod_sclk_gen #(
    .DIV(DIV)
  ) u_sclk_gen (
    .clock (clock),
    .resetn(resetn),
    .start (gen_start),
    .run   (gen_run),
    .sclk  (sclk),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  always_ff @(posedge clock) begin
    if (resetn || !en) begin
      period_cnt <= '0;
    end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
      period_cnt <= '0;
    end else begin
      period_cnt <= period_cnt + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      sdata_q  <= 1'b0;
      cs       <= 1'b1;
      busy     <= 1'b0;
      valid    <= 1'b0;
      dataout  <= '0;
    end else begin
      sdata_q <= sdata;
      valid   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en && period_cnt == '0) begin
            state    <= ST_LEAD;
            wait_cnt <= '0;
            bit_cnt  <= '0;
            cs       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_LEAD: begin
          if (wait_done) begin
            state <= ST_SHIFT;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_SHIFT: begin
          // sdata_q has been stable since the previous falling half-period.
          if (sclk_rise) begin
            bit_cnt <= bit_cnt + BW'(1);
            shreg   <= {shreg[KEEP-2:0], sdata_q};
          end
          if (shift_done) begin
            state    <= ST_TAIL;
            wait_cnt <= '0;
          end
        end
        ST_TAIL: begin
          if (wait_done) begin
            state   <= ST_IDLE;
            cs      <= 1'b1;
            busy    <= 1'b0;
            valid   <= 1'b1;
            dataout <= frame_sample ^ MSB_MASK;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pmod_adc_rx.md
# pmod_adc_rx

Serial receiver for a 12-bit Pmod ADC: the read-side counterpart of the Pmod DAC transmitter, sharing the same cs/sclk/data wiring style. Generates chip-select and serial clock, shifts in one 16-bit frame per sample period, strips leading zeros and presents a 12-bit sample with a one-cycle valid strobe. Sits between the ADC pins and the DSP datapath (e.g. feeding filters or loopback against the CORDIC sine).

## Interface
- WIDTH, 12, sample bits kept per frame
- FRAME_BITS, 16, sclk cycles per frame
- LEAD_ZEROS, 4, leading bits discarded (must satisfy LEAD_ZEROS+WIDTH <= FRAME_BITS)
- DIV, 2, clock cycles per sclk half-period (>= 2)
- SAMPLE_PERIOD, 256, clock cycles between frame starts (>= (2*FRAME_BITS+4)*DIV)
- SIGNED_OUT, 1, 1 = convert offset binary to two's complement (invert MSB)

- clock  input  1  system clock; single clock domain
- resetn  input  1  synchronous, active-high reset (name kept for codebase consistency)
- en  input  1  enables conversions
- sdata  input  1  ADC serial data
- cs  output  1  chip select, active low
- sclk  output  1  serial clock, idles high
- dataout  output  WIDTH  last sample, held between valid strobes
- valid  output  1  one-cycle pulse when dataout updates
- busy  output  1  high while cs is low

## Operation
- States: IDLE, LEAD, SHIFT, TAIL.
- Period counter: counts 0..SAMPLE_PERIOD-1 while en=1, wraps; held at 0 while en=0.
- IDLE: cs=1, sclk=1. If en=1 and period counter==0, go to LEAD.
- LEAD: cs=0, sclk=1 for DIV cycles, then SHIFT.
- SHIFT: sclk starts low, toggles every DIV cycles; exactly FRAME_BITS low and FRAME_BITS high phases. sdata registered once (sdata_q); on each cycle where sclk goes 0->1, bit counter increments and sdata_q shifts in MSB first. After FRAME_BITS-th rising edge, go to TAIL.
- TAIL: cs=0, sclk=1 for DIV cycles, then IDLE.
- On TAIL->IDLE edge: dataout <= last WIDTH shifted bits (bits LEAD_ZEROS..LEAD_ZEROS+WIDTH-1 of frame); if SIGNED_OUT, MSB inverted. valid=1 for that single cycle, coincident with cs returning high.
- Leading-bit content ignored (no error flag).
- en deasserted mid-frame: current frame completes and produces valid; no further frame.
- resetn=1 at any time, incl. mid-frame: state IDLE, counters 0, cs=1, sclk=1, valid=0, busy=0, dataout=0 on next edge; partial frame discarded, no valid.
- Parameter violations (SAMPLE_PERIOD, LEAD_ZEROS+WIDTH, DIV) are elaboration-time errors.

## Timing
- Reset values: cs=1, sclk=1, dataout=0, valid=0, busy=0.
- en rises at edge t (counter at 0): cs falls at edge t+1.
- cs low duration: (2*FRAME_BITS+2)*DIV cycles (68 at defaults).
- valid asserted (2*FRAME_BITS+2)*DIV cycles after cs falls; dataout stable from that edge until next valid.
- Frame starts every SAMPLE_PERIOD cycles while en=1; cs high at least 2*DIV cycles between frames.
- Each sampled bit is stable in sdata_q for >= DIV-1 cycles before the rising sclk edge.
- busy == ~cs, registered.

## Structure
- Shared package pmod_pkg: state enum, default WIDTH/FRAME_BITS/LEAD_ZEROS constants (shared with the DAC transmitter so both ends agree on frame format).
- One sub-module: pmod_sclk_gen — DIV-based half-period counter producing sclk level plus one-cycle rise/fall strokes, enabled only in SHIFT. FSM, period counter, shift register stay in pmod_adc_rx.

## Test plan
- Reset: hold resetn=1 5 cycles with en=1 -> cs=1, sclk=1, dataout=0, valid=0 throughout.
- Single frame, defaults: ADC model drives 0000_1010_1011_1100 -> cs low 68 cycles, 16 sclk rises, valid once, dataout=12'h2BC (MSB-inverted of 12'hABC); SIGNED_OUT=0 gives 12'hABC.
- Extremes: frames 0x0FFF and 0x0000 -> dataout 12'h7FF and 12'h800 (signed); leading bits driven to 1 -> ignored, same result.
- Continuous: en=1 for 1024 cycles -> exactly 4 valid strobes 256 cycles apart, cs high >= 4 cycles between frames; ramp data reproduced in order.
- Reset mid-frame: assert resetn at 8th sclk rise -> cs=1 next edge, no valid, dataout unchanged at 0; subsequent frame correct.
- en drop mid-frame: deassert en at 5th sclk rise -> frame completes with valid and correct data; no further cs activity.
